// File: rtl/legv8_imm_encoder_if.sv
// rtl/legv8_imm_encoder_if.sv - request and memory-write bus of the LEGv8 immediate encoder
// master is the loader front end, slave is the encoder.
interface legv8_imm_encoder_if #(
  parameter int AW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    kind;
  logic [4:0]    rt;
  logic [4:0]    rn;
  logic [63:0]   imm;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  modport master (
    output in_valid, kind, rt, rn, imm,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, kind, rt, rn, imm,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/legv8_imm_encoder.sv
// rtl/legv8_imm_encoder.sv - packs LDUR/STUR/CBZ/B.cond fields into words and writes them sequentially
// Immediates that would not sign-extend back to themselves are rejected and counted.
module legv8_imm_encoder #(
  parameter int AW = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  legv8_imm_encoder_if.slave  bus,
  output logic                rej,
  output logic [7:0]          err_count,
  output logic                full
);
  typedef enum logic [2:0] {IDLE, ENC, WRITE, REJ, FULL} state_t;

  state_t        st;
  logic [1:0]    kind_q;
  logic [4:0]    rt_q;
  logic [4:0]    rn_q;
  logic [63:0]   imm_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [31:0]   wr_data_q;
  logic [31:0]   enc_word;
  logic          fits;
  logic          last_addr;

  assign bus.in_ready = (st == IDLE);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign last_addr    = (wr_addr_q == {AW{1'b1}});

  // A field fits when every bit above it matches its sign bit.
  always_comb begin
    enc_word = 32'd0;
    fits     = 1'b0;
    case (kind_q)
      2'd0: begin
        enc_word = {11'b111_1100_0010, imm_q[8:0], 2'b00, rn_q, rt_q};
        fits     = (&imm_q[63:8]) | ~(|imm_q[63:8]);
      end
      2'd1: begin
        enc_word = {11'b111_1100_0000, imm_q[8:0], 2'b00, rn_q, rt_q};
        fits     = (&imm_q[63:8]) | ~(|imm_q[63:8]);
      end
      2'd2: begin
        enc_word = {8'b1011_0100, imm_q[18:0], rt_q};
        fits     = (&imm_q[63:18]) | ~(|imm_q[63:18]);
      end
      default: begin
        enc_word = {8'b0101_0100, imm_q[18:0], rt_q};
        fits     = (&imm_q[63:18]) | ~(|imm_q[63:18]);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      kind_q    <= 2'd0;
      rt_q      <= 5'd0;
      rn_q      <= 5'd0;
      imm_q     <= 64'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 32'd0;
      rej       <= 1'b0;
      err_count <= 8'd0;
      full      <= 1'b0;
    end else if (clear) begin
      // wr_data is left alone: it only has meaning while wr_en is high.
      st        <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rej       <= 1'b0;
      err_count <= 8'd0;
      full      <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.in_valid) begin
            kind_q <= bus.kind;
            rt_q   <= bus.rt;
            rn_q   <= bus.rn;
            imm_q  <= bus.imm;
            st     <= ENC;
          end
        end
        ENC: begin
          if (fits) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= enc_word;
            st        <= WRITE;
          end else begin
            rej <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            st  <= REJ;
          end
        end
        WRITE: begin
          wr_en_q   <= 1'b0;
          wr_addr_q <= wr_addr_q + 1'b1;
          if (last_addr) begin
            full <= 1'b1;
            st   <= FULL;
          end else begin
            st <= IDLE;
          end
        end
        REJ: begin
          rej <= 1'b0;
          st  <= IDLE;
        end
        FULL:    st <= FULL;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_legv8_imm_encoder.sv
// tb/tb_legv8_imm_encoder.sv - scoreboard bench for legv8_imm_encoder with a 4-word memory
// Expected writes/rejects are queued at acceptance and popped by a negedge monitor.
module tb_legv8_imm_encoder;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       rej;
  logic [7:0] err_count;
  logic       full;

  legv8_imm_encoder_if #(.AW(AW)) bus ();

  legv8_imm_encoder #(.AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .bus       (bus),
    .rej       (rej),
    .err_count (err_count),
    .full      (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rej;
    logic [1:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_addr = 0;
  int   m_err = 0;
  bit   m_full = 0;

  function automatic bit ref_fits(input logic [1:0] k, input longint i);
    if (k < 2) return (i >= -256) && (i <= 255);
    return (i >= -262144) && (i <= 262143);
  endfunction

  function automatic logic [31:0] ref_enc(input logic [1:0] k, input logic [4:0] t,
                                          input logic [4:0] n, input longint i);
    longint w;
    if (k < 2)
      w = ((k == 0) ? 64'h7C2 : 64'h7C0) * 2097152 + (i & 511) * 4096 + longint'(n) * 32 + longint'(t);
    else
      w = ((k == 2) ? 64'hB4 : 64'h54) * 16777216 + (i & 64'h7FFFF) * 32 + longint'(t);
    return w[31:0];
  endfunction

  task automatic model_accept(input logic [1:0] k, input logic [4:0] t, input logic [4:0] n,
                              input longint i);
    if (ref_fits(k, i)) begin
      q.push_back('{1'b0, 2'(m_addr), ref_enc(k, t, n, i)});
      m_addr++;
      if (m_addr == DEPTH) begin
        m_addr = 0;
        m_full = 1;
      end
    end else begin
      q.push_back('{1'b1, 2'd0, 32'd0});
      if (m_err < 255) m_err++;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Returns just after the accept edge, i.e. while the DUT is encoding.
  task automatic send(input logic [1:0] k, input logic [4:0] t, input logic [4:0] n,
                      input longint i, input bit track);
    bit ok = 0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout in_ready=0 required=1");
      return;
    end
    bus.kind     = k;
    bus.rt       = t;
    bus.rn       = n;
    bus.imm      = i;
    bus.in_valid = 1'b1;
    if (track) model_accept(k, t, n, i);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    m_addr = 0;
    m_err  = 0;
    m_full = 0;
  endtask

  function automatic longint gen_imm(input logic [1:0] k);
    longint lo = (k < 2) ? -256 : -262144;
    longint hi = (k < 2) ? 255 : 262143;
    case ($urandom_range(0, 5))
      0: return lo + longint'($urandom_range(0, 32'(hi - lo)));
      1: return lo;
      2: return hi;
      3: return lo - 1;
      4: return hi + 1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_en || rej) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event wr_en=%0b rej=%0b addr=%0d data=0x%08h required=none",
                   bus.wr_en, rej, bus.wr_addr, bus.wr_data);
        end else begin
          e = q.pop_front();
          if (e.is_rej ? !(rej && !bus.wr_en)
                       : !(bus.wr_en && !rej && bus.wr_addr == e.addr && bus.wr_data == e.data)) begin
            n_bad++;
            $display("FAIL event wr_en=%0b rej=%0b addr=%0d data=0x%08h required rej=%0b addr=%0d data=0x%08h",
                     bus.wr_en, rej, bus.wr_addr, bus.wr_data, e.is_rej, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int seen;
    logic [1:0] k;
    bus.in_valid = 1'b0;
    bus.kind = 2'd0;
    bus.rt = 5'd0;
    bus.rn = 5'd0;
    bus.imm = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_wr_en", bus.wr_en, 0);
    chk("reset_wr_addr", bus.wr_addr, 0);
    chk("reset_wr_data", bus.wr_data, 0);
    chk("reset_rej", rej, 0);
    chk("reset_err_count", err_count, 0);
    chk("reset_full", full, 0);
    @(negedge clk);
    reset = 1'b1;

    send(2'd0, 5'd1, 5'd2, -4, 1);
    chk("ldur_enc_not_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("ldur_wr_en", bus.wr_en, 1);
    chk("ldur_wr_data", bus.wr_data, 32'hF85FC041);
    chk("ldur_wr_addr", bus.wr_addr, 0);
    @(posedge clk);
    #1;
    chk("ldur_wr_en_drop", bus.wr_en, 0);
    chk("ldur_addr_inc", bus.wr_addr, 1);
    chk("ldur_ready_back", bus.in_ready, 1);
    do_clear();

    send(2'd2, 5'd3, 5'd0, 16, 1);
    send(2'd3, 5'd1, 5'd0, -1, 1);
    settle();
    chk("branch_pair_addr", bus.wr_addr, 2);
    do_clear();

    send(2'd1, 5'd4, 5'd5, 255, 1);
    send(2'd1, 5'd4, 5'd5, 256, 1);
    settle();
    chk("stur256_err_count", err_count, 1);
    chk("stur256_addr_hold", bus.wr_addr, 1);
    send(2'd2, 5'd6, 5'd0, -262145, 1);
    settle();
    chk("cbz_low_err_count", err_count, 2);
    send(2'd1, 5'd7, 5'd8, -256, 1);
    send(2'd0, 5'd7, 5'd8, -257, 1);
    send(2'd2, 5'd9, 5'd0, 262143, 1);
    send(2'd3, 5'd9, 5'd0, 262144, 1);
    send(2'd2, 5'd9, 5'd0, -262144, 1);
    settle();
    chk("full_flag", full, m_full);
    chk("full_not_ready", bus.in_ready, 0);
    chk("full_err_count", err_count, m_err);
    chk("full_addr_wrap", bus.wr_addr, 0);

    seen = 0;
    @(negedge clk);
    bus.kind = 2'd0;
    bus.imm = 64'd8;
    bus.in_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.wr_en) seen++;
    end
    bus.in_valid = 1'b0;
    chk("held_fifth_no_write", seen, 0);
    chk("held_fifth_full", full, 1);
    do_clear();
    #1;
    chk("clear_wr_addr", bus.wr_addr, 0);
    chk("clear_full", full, 0);
    chk("clear_in_ready", bus.in_ready, 1);
    chk("clear_err_count", err_count, 0);

    send(2'd0, 5'd1, 5'd1, 8, 1);
    send(2'd1, 5'd1, 5'd1, 1000, 1);
    settle();
    send(2'd0, 5'd1, 5'd2, -4, 0);
    @(posedge clk);
    #1;
    chk("pre_reset_wr_en", bus.wr_en, 1);
    reset = 1'b0;
    #1;
    chk("reset_mid_write_wr_en", bus.wr_en, 0);
    chk("reset_mid_write_addr", bus.wr_addr, 0);
    chk("reset_mid_write_err", err_count, 0);
    m_addr = 0;
    m_err = 0;
    m_full = 0;
    @(negedge clk);
    reset = 1'b1;

    send(2'd3, 5'd2, 5'd0, 12, 1);
    send(2'd2, 5'd2, 5'd0, 1 << 20, 1);
    settle();
    send(2'd1, 5'd1, 5'd1, 4096, 0);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    m_addr = 0;
    m_err = 0;
    m_full = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("clear_enc_addr", bus.wr_addr, 0);
    chk("clear_enc_err", err_count, 0);
    chk("clear_enc_ready", bus.in_ready, 1);

    for (int n = 0; n < 60; n++) begin
      if (m_full) begin
        chk("rand_full", full, 1);
        do_clear();
      end
      k = 2'($urandom_range(0, 3));
      send(k, 5'($urandom), 5'($urandom), gen_imm(k), 1);
      settle();
    end
    chk("rand_err_count", err_count, m_err);
    chk("rand_addr", bus.wr_addr, m_addr);

    do_clear();
    for (int n = 0; n < 300; n++) begin
      k = 2'($urandom_range(0, 3));
      send(k, 5'd0, 5'd0, (k < 2) ? 256 + longint'($urandom_range(0, 999))
                                  : -262145 - longint'($urandom_range(0, 999)), 1);
    end
    settle();
    chk("sat_err_count", err_count, 255);
    chk("sat_model", m_err, 255);
    chk("sat_addr", bus.wr_addr, 0);

    repeat (2) @(posedge clk);
    chk("pending_expect", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
